hazard_detection_unit: RTL and testbench

//   Load-use hazard detector for the 5-stage RV32 pipeline, sitting in the ID stage.

---
 rtl/hazard_detection_unit_pkg.sv | 14 +
 rtl/hazard_detection_unit_compare.sv | 30 +++
 rtl/hazard_detection_unit.sv | 65 ++++++
 tb/tb_hazard_detection_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline definitions for the ID-stage hazard logic.
// This package holds the register-index width, the x0 encoding and the index type.
package hazard_detection_unit_pkg;

    // Width of a register-file index (x0..x31 for RV32).
    localparam int REG_ADDR_W = 5;

    // Register-file index type used by all ID-stage comparators.
    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    // x0 is hardwired to zero, so a write to it never produces a value worth waiting for.
    localparam reg_idx_t REG_X0 = '0;

endpackage : hazard_detection_unit_pkg

// File: rtl/hazard_detection_unit_compare.sv
// Load-use comparator.
// It raises hazard when the load in ID/EX writes a non-x0 register that the
// instruction in IF/ID reads through rs1 or rs2.
module hazard_compare
    import hazard_detection_unit_pkg::*;
(
    input  reg_idx_t rs1,
    input  reg_idx_t rs2,
    input  reg_idx_t rd,
    input  logic     mem_read,
    output logic     hazard
);

    logic rd_live;
    logic src_match;

    // Detect a load whose destination is read by the next instruction.
    always_comb begin
        // NOTE: every signal gets a default first so that no path can leave it unassigned and infer a latch.
        rd_live   = 1'b0;
        src_match = 1'b0;
        hazard    = 1'b0;

        rd_live   = (rd != REG_X0);
        src_match = (rd == rs1) || (rd == rs2);
        // ALU producers are covered by forwarding; only a load result arrives too late.
        hazard    = mem_read && rd_live && src_match;
    end

endmodule : hazard_compare

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detection unit for the ID stage of the 5-stage RV32 pipeline.
// It freezes PC and IF/ID and bubbles ID/EX while a load-use hazard is present,
// and keeps a registered copy of the last hazard plus a saturating stall counter.
module hazard_detection_unit #(
    parameter int REG_ADDR_W = hazard_detection_unit_pkg::REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] if_id_rs1,
    input  logic [REG_ADDR_W-1:0] if_id_rs2,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  id_ex_mem_read,
    output logic                  PCWrite,
    output logic                  if_id_write,
    output logic                  control_mux_sig,
    output logic                  stall_prev,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic hazard;

    hazard_compare u_compare (
        .rs1      (if_id_rs1),
        .rs2      (if_id_rs2),
        .rd       (id_ex_rd),
        .mem_read (id_ex_mem_read),
        .hazard   (hazard)
    );

    // Stall controls follow the inputs with zero latency and are independent of reset.
    always_comb begin
        PCWrite         = 1'b1;
        if_id_write     = 1'b1;
        control_mux_sig = 1'b0;
        if (hazard) begin
            PCWrite         = 1'b0;
            if_id_write     = 1'b0;
            control_mux_sig = 1'b1;
        end
    end

    // Remember whether the previous cycle was a stall cycle.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            stall_prev <= 1'b0;
        end else begin
            stall_prev <= hazard;
        end
    end

    // Count stall cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (hazard && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_ONE;
        end
    end

endmodule : hazard_detection_unit

// File: tb/tb_hazard_detection_unit.sv
// Directed self-checking bench for hazard_detection_unit.
// A default 32-bit-counter instance and a 4-bit-counter instance share the same stimulus.
module tb_hazard_detection_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  if_id_rs1;
    logic [4:0]  if_id_rs2;
    logic [4:0]  id_ex_rd;
    logic        id_ex_mem_read;

    logic        pc_write;
    logic        if_id_write;
    logic        control_mux_sig;
    logic        stall_prev;
    logic [31:0] stall_count;

    logic        pc_write_s;
    logic        if_id_write_s;
    logic        control_mux_sig_s;
    logic        stall_prev_s;
    logic [3:0]  stall_count_s;

    int checks;
    int errors;

    hazard_detection_unit dut (
        .clk             (clk),
        .rst             (rst),
        .if_id_rs1       (if_id_rs1),
        .if_id_rs2       (if_id_rs2),
        .id_ex_rd        (id_ex_rd),
        .id_ex_mem_read  (id_ex_mem_read),
        .PCWrite         (pc_write),
        .if_id_write     (if_id_write),
        .control_mux_sig (control_mux_sig),
        .stall_prev      (stall_prev),
        .stall_count     (stall_count)
    );

    hazard_detection_unit #(.CNT_W(4)) dut_small (
        .clk             (clk),
        .rst             (rst),
        .if_id_rs1       (if_id_rs1),
        .if_id_rs2       (if_id_rs2),
        .id_ex_rd        (id_ex_rd),
        .id_ex_mem_read  (id_ex_mem_read),
        .PCWrite         (pc_write_s),
        .if_id_write     (if_id_write_s),
        .control_mux_sig (control_mux_sig_s),
        .stall_prev      (stall_prev_s),
        .stall_count     (stall_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        id_ex_mem_read = mr;
        if_id_rs1      = rs1;
        if_id_rs2      = rs2;
        id_ex_rd       = rd;
    endtask

    // Expected stall controls as {PCWrite, if_id_write, control_mux_sig} for both instances.
    task automatic check_ctrl(input string tag, input logic [2:0] expected);
        #1;
        check({tag, " ctrl"},       {29'd0, pc_write, if_id_write, control_mux_sig}, {29'd0, expected});
        check({tag, " ctrl_small"}, {29'd0, pc_write_s, if_id_write_s, control_mux_sig_s}, {29'd0, expected});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0);

        // Reset state and idle controls.
        #1;
        check("reset stall_prev", {31'd0, stall_prev}, 32'd0);
        check("reset stall_count", stall_count, 32'd0);
        check("reset stall_count_small", {28'd0, stall_count_small_w()}, 32'd0);
        check_ctrl("idle", 3'b110);

        // Combinational vectors, evaluated while reset is held to show reset does not gate them.
        drive(1'b1, 5'b10101, 5'b00000, 5'b10101);
        check_ctrl("rs1 match", 3'b001);
        drive(1'b1, 5'b00000, 5'b10101, 5'b10101);
        check_ctrl("rs2 match", 3'b001);
        drive(1'b1, 5'b10101, 5'b10101, 5'b10101);
        check_ctrl("both match", 3'b001);
        drive(1'b0, 5'b00000, 5'b01010, 5'b01010);
        check_ctrl("no load rs2", 3'b110);
        drive(1'b0, 5'b10101, 5'b11111, 5'b10101);
        check_ctrl("no load rs1", 3'b110);
        drive(1'b1, 5'b00000, 5'b11111, 5'b10101);
        check_ctrl("load no match", 3'b110);
        drive(1'b1, 5'b00000, 5'b00011, 5'b00000);
        check_ctrl("x0 exempt", 3'b110);
        check("in reset count", stall_count, 32'd0);

        // Release reset with no hazard: nothing should be counted.
        drive(1'b0, 5'd1, 5'd2, 5'd3);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle count", stall_count, 32'd0);
        check("idle stall_prev", {31'd0, stall_prev}, 32'd0);

        // Hold a load-use hazard for three edges.
        @(negedge clk);
        drive(1'b1, 5'b10101, 5'b00000, 5'b10101);
        repeat (3) @(posedge clk);
        #1;
        check("held stall_prev", {31'd0, stall_prev}, 32'd1);
        check("held count", stall_count, 32'd3);
        check("held count_small", {28'd0, stall_count_small_w()}, 32'd3);

        // Asynchronous reset mid-cycle clears state with no clock edge.
        #1;
        rst = 1'b1;
        #1;
        check("async stall_prev", {31'd0, stall_prev}, 32'd0);
        check("async count", stall_count, 32'd0);
        check("async count_small", {28'd0, stall_count_small_w()}, 32'd0);
        check_ctrl("hazard in reset", 3'b001);

        // Release reset mid-stall: counting begins on the first edge afterwards.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post release count", stall_count, 32'd0);
        @(posedge clk);
        #1;
        check("first edge count", stall_count, 32'd1);
        check("first edge stall_prev", {31'd0, stall_prev}, 32'd1);

        // Hold until the narrow counter has reached its limit and would wrap without saturation.
        repeat (13) @(posedge clk);
        #1;
        check("count_small 14", {28'd0, stall_count_small_w()}, 32'd14);
        @(posedge clk);
        #1;
        check("count_small 15", {28'd0, stall_count_small_w()}, 32'd15);
        repeat (5) @(posedge clk);
        #1;
        check("count 20", stall_count, 32'd20);
        check("count_small saturated", {28'd0, stall_count_small_w()}, 32'hF);

        // Clearing the hazard holds the counters and drops stall_prev.
        @(negedge clk);
        drive(1'b0, 5'b10101, 5'b00000, 5'b10101);
        check_ctrl("hazard cleared", 3'b110);
        @(posedge clk);
        #1;
        check("clear stall_prev", {31'd0, stall_prev}, 32'd0);
        check("clear count", stall_count, 32'd20);
        check("clear count_small", {28'd0, stall_count_small_w()}, 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [3:0] stall_count_small_w();
        return stall_count_s;
    endfunction

endmodule : tb_hazard_detection_unit
